logic_reduce_unit: RTL and testbench

//  Parametrised, sequential successor to the two-input AND gate.

---
 rtl/logic_reduce_unit_if.sv | 25 ++
 rtl/logic_reduce_unit.sv | 118 +++++++++++
 tb/tb_logic_reduce_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/logic_reduce_unit_if.sv
// Handshake bundle for logic_reduce_unit: operand input port, result output port and status.
// The source/consumer side uses master; the reduction unit uses slave.
interface logic_reduce_unit_if #(
    parameter int WIDTH = 8
);
    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] In_data;
    logic [2:0]       Op;
    logic             Out_valid;
    logic             Out_ready;
    logic [WIDTH-1:0] Out_data;
    logic             Op_err;
    logic             Busy;

    modport master (
        output In_valid, In_data, Op, Out_ready,
        input  In_ready, Out_valid, Out_data, Op_err, Busy
    );

    modport slave (
        input  In_valid, In_data, Op, Out_ready,
        output In_ready, Out_valid, Out_data, Op_err, Busy
    );
endinterface

// File: rtl/logic_reduce_unit.sv
// Sequential bitwise reducer: folds N_OPS operands with AND/OR/XOR (optionally inverted)
// and holds the registered result on a valid/ready port until it is taken.
module logic_reduce_unit #(
    parameter int WIDTH = 8,
    parameter int N_OPS = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Flush,
    logic_reduce_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(N_OPS) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   acc_q,      acc_d;
    logic [2:0]         op_q,       op_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               op_err_q,   op_err_d;

    logic               accept;
    logic               deliver;
    logic [WIDTH-1:0]   folded;
    logic               invert;
    logic               reserved;

    // Only the base operation is applied while folding; inversion happens once at the result.
    function automatic logic [WIDTH-1:0] fold_base(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            3'b001, 3'b100: fold_base = a | b;
            3'b010, 3'b101: fold_base = a ^ b;
            default:        fold_base = a & b;
        endcase
    endfunction

    assign bus.In_ready  = (state_q != S_DONE);
    assign bus.Out_valid = (state_q == S_DONE);
    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Out_data  = out_data_q;
    assign bus.Op_err    = op_err_q;

    assign accept   = bus.In_valid && bus.In_ready;
    assign deliver  = bus.Out_valid && bus.Out_ready;
    assign folded   = fold_base(op_q, acc_q, bus.In_data);
    assign invert   = (op_q == 3'b011) || (op_q == 3'b100) || (op_q == 3'b101);
    assign reserved = op_q[2] && op_q[1];

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        op_err_d   = op_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = bus.In_data;
                    op_d    = bus.Op;
                    cnt_d   = CNT_W'(1);
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d = folded;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_OPS - 1)) begin
                        out_data_d = invert ? ~folded : folded;
                        op_err_d   = reserved;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (deliver) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over any accept or deliver in the same cycle.
        if (Flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            op_err_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            op_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            op_err_q   <= op_err_d;
        end
    end
endmodule

// File: tb/tb_logic_reduce_unit.sv
// Directed plus random stimulus for logic_reduce_unit; expected results go through a
// scoreboard queue and are compared when the unit delivers a result.
module tb_logic_reduce_unit;
    localparam int WIDTH = 8;
    localparam int N_OPS = 4;

    logic Clk;
    logic Rst_n;
    logic Flush;

    logic_reduce_unit_if #(.WIDTH(WIDTH)) bus ();

    logic_reduce_unit #(.WIDTH(WIDTH), .N_OPS(N_OPS)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Flush (Flush),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];   // {op_err, data}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain sequential fold, then inversion for the inverted op codes.
    function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c,
                                         input logic [7:0] d);
        logic [7:0] v[4];
        logic [7:0] r;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        r = v[0];
        for (int k = 1; k < 4; k++) begin
            if (op == 3'd1 || op == 3'd4)      r = r | v[k];
            else if (op == 3'd2 || op == 3'd5) r = r ^ v[k];
            else                               r = r & v[k];
        end
        if (op == 3'd3 || op == 3'd4 || op == 3'd5) r = ~r;
        return {(op >= 3'd6), r};
    endfunction

    // Present one operand and hold it until accepted (bounded).
    task automatic send(input logic [7:0] d, input logic [2:0] op);
        int n;
        n = 0;
        @(negedge Clk);
        bus.In_valid = 1'b1;
        bus.In_data  = d;
        bus.Op       = op;
        while (!bus.In_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", {31'd0, bus.In_ready}, 32'd1);
        @(posedge Clk);
        #1;
        bus.In_valid = 1'b0;
    endtask

    task automatic send_set(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, input int gap);
        send(a, op);
        repeat (gap) @(negedge Clk);
        send(b, 3'd0);
        repeat (gap) @(negedge Clk);
        send(c, 3'd0);
        repeat (gap) @(negedge Clk);
        send(d, 3'd0);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
    endtask

    // Result monitor: pops the scoreboard on every delivery.
    always @(negedge Clk) begin
        if (Rst_n && !Flush && bus.Out_valid && bus.Out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {23'd0, bus.Op_err, bus.Out_data}, 32'h1ff);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                $display("result data=%02h op_err=%0b expected data=%02h op_err=%0b",
                         bus.Out_data, bus.Op_err, e[7:0], e[8]);
                chk("out_data", {24'd0, bus.Out_data}, {24'd0, e[7:0]});
                chk("op_err", {31'd0, bus.Op_err}, {31'd0, e[8]});
            end
        end
    end

    initial begin
        logic [7:0] r0, r1, r2, r3;
        logic [2:0] rop;

        Rst_n = 1'b0;
        Flush = 1'b0;
        bus.In_valid  = 1'b0;
        bus.In_data   = '0;
        bus.Op        = '0;
        bus.Out_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.Out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, bus.Out_data}, 32'd0);
        chk("rst_op_err", {31'd0, bus.Op_err}, 32'd0);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.In_ready}, 32'd1);
        Rst_n = 1'b1;

        // 1: AND, latency and single-cycle valid
        sb.push_back({1'b0, 8'h32});
        send_set(3'b000, 8'hFF, 8'hF3, 8'h7E, 8'h3F, 0);
        chk("and_valid_next_cycle", {31'd0, bus.Out_valid}, 32'd1);
        chk("and_data_direct", {24'd0, bus.Out_data}, 32'h32);
        @(posedge Clk); #1;
        chk("and_valid_one_cycle", {31'd0, bus.Out_valid}, 32'd0);

        // 2: XNOR, NOR
        sb.push_back({1'b0, 8'h96});
        send_set(3'b101, 8'h0F, 8'h33, 8'h55, 8'h00, 0);
        sb.push_back({1'b0, 8'hF0});
        send_set(3'b100, 8'h01, 8'h02, 8'h04, 8'h08, 0);
        drain();

        // 3: backpressure, ignored input pulses
        bus.Out_ready = 1'b0;
        sb.push_back({1'b0, 8'h32});
        send_set(3'b000, 8'hFF, 8'hF3, 8'h7E, 8'h3F, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_out_valid", {31'd0, bus.Out_valid}, 32'd1);
            chk("bp_out_data", {24'd0, bus.Out_data}, 32'h32);
            chk("bp_in_ready", {31'd0, bus.In_ready}, 32'd0);
            bus.In_valid = i[0];
            bus.In_data  = 8'h55;
        end
        @(negedge Clk);
        bus.In_valid  = 1'b0;
        bus.Out_ready = 1'b1;
        drain();
        @(negedge Clk);
        chk("bp_idle_busy", {31'd0, bus.Busy}, 32'd0);
        chk("bp_idle_in_ready", {31'd0, bus.In_ready}, 32'd1);

        // 4: op latched with first operand, with and without gaps
        sb.push_back({1'b0, 8'h87});
        send_set(3'b001, 8'h01, 8'h02, 8'h04, 8'h80, 0);
        sb.push_back({1'b0, 8'h87});
        send_set(3'b001, 8'h01, 8'h02, 8'h04, 8'h80, 3);
        drain();

        // 5: flush mid-set, then a clean AND set
        send(8'h00, 3'b001);
        send(8'h00, 3'b000);
        @(negedge Clk);
        Flush = 1'b1;
        @(posedge Clk); #1;
        Flush = 1'b0;
        chk("flush_busy", {31'd0, bus.Busy}, 32'd0);
        chk("flush_in_ready", {31'd0, bus.In_ready}, 32'd1);
        sb.push_back({1'b0, 8'h0F});
        send_set(3'b000, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 0);
        drain();

        // Flush of a held result
        bus.Out_ready = 1'b0;
        send_set(3'b111, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 0);
        chk("held_op_err", {31'd0, bus.Op_err}, 32'd1);
        @(negedge Clk);
        Flush = 1'b1;
        @(posedge Clk); #1;
        Flush = 1'b0;
        bus.Out_ready = 1'b1;
        chk("flush_held_valid", {31'd0, bus.Out_valid}, 32'd0);
        chk("flush_held_op_err", {31'd0, bus.Op_err}, 32'd0);

        // Reset mid-ACCUM
        send(8'h12, 3'b010);
        send(8'h34, 3'b000);
        @(negedge Clk);
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("midrst_out_data", {24'd0, bus.Out_data}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.In_ready}, 32'd1);
        Rst_n = 1'b1;
        sb.push_back(model(3'b010, 8'h11, 8'h22, 8'h44, 8'h88));
        send_set(3'b010, 8'h11, 8'h22, 8'h44, 8'h88, 0);
        drain();

        // 6: reserved op, then back-to-back set right after delivery
        sb.push_back({1'b1, 8'h30});
        send_set(3'b110, 8'hFF, 8'hFF, 8'hF0, 8'h3C, 0);
        sb.push_back({1'b0, 8'h0F});
        send_set(3'b000, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 0);
        drain();

        // Random sets over all op codes
        for (int s = 0; s < 8; s++) begin
            rop = 3'(s);
            r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
            sb.push_back(model(rop, r0, r1, r2, r3));
            send_set(rop, r0, r1, r2, r3, s % 2);
        end
        drain();

        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
